// File: rtl/add_tree_pkg.sv
// ============================================================================
// Package : add_tree_pkg
// Purpose : Shared helpers for the pipelined adder tree (add_tree_pipe).
//           - clog2            : ceiling log2 used to derive the tree depth
//           - calc_levels      : number of register levels for NUM_IN operands
//           - calc_full_w      : full-precision result width (no truncation)
//           - bus_offset       : bit offset of a level inside the packed
//                                inter-stage bus
//           - stage_valid_t    : generic per-stage valid vector type
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package add_tree_pkg;

  localparam int MAX_LEVELS = 16;

  typedef logic [MAX_LEVELS-1:0] stage_valid_t;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  function automatic int calc_levels(input int num_in);
    return clog2(num_in);
  endfunction

  function automatic int calc_full_w(input int num_in, input int in_w);
    return in_w + clog2(num_in);
  endfunction

  // Level j of the tree carries (num_in >> j) values of (in_w + j) bits.
  // Levels are packed back to back, level 0 (the raw operands) at bit 0.
  function automatic int bus_offset(input int num_in, input int in_w, input int level);
    int off;
    off = 0;
    for (int j = 0; j < level; j++) begin
      off = off + (num_in >> j) * (in_w + j);
    end
    return off;
  endfunction

endpackage

`default_nettype wire

// File: rtl/add_tree_stage.sv
// ============================================================================
// Module  : add_tree_stage
// Purpose : One register level of the adder tree. Adds N_PAIRS pairs of W-bit
//           unsigned values into N_PAIRS (W+1)-bit sums and registers them
//           together with a valid bit whenever the stage is allowed to advance.
// Ports   : clk      - clock, rising edge
//           rst_n    - asynchronous reset, active low
//           i_adv    - stage loads this cycle
//           i_valid  - upstream valid
//           i_data   - 2*N_PAIRS operands of W bits, pair p = operands 2p,2p+1
//           o_valid  - registered valid
//           o_data   - N_PAIRS registered sums of W+1 bits
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module add_tree_stage
  import add_tree_pkg::*;
#(
  parameter int N_PAIRS = 4,
  parameter int W       = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_adv,
  input  logic                     i_valid,
  input  logic [2*N_PAIRS*W-1:0]   i_data,
  output logic                     o_valid,
  output logic [N_PAIRS*(W+1)-1:0] o_data
);

  logic [N_PAIRS*(W+1)-1:0] w_sum;
  logic [N_PAIRS*(W+1)-1:0] r_data;
  logic                     r_valid;

  for (genvar p = 0; p < N_PAIRS; p++) begin : g_pair
    assign w_sum[p*(W+1) +: W+1] = {1'b0, i_data[(2*p)*W +: W]}
                                 + {1'b0, i_data[(2*p+1)*W +: W]};
  end

  // Data loads on every advance, even with no valid token; the valid bit
  // alone qualifies it, which keeps the enable path a single signal.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_adv) begin
      r_valid <= i_valid;
      r_data  <= w_sum;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

`default_nettype wire

// File: rtl/add_tree_pipe.sv
// ============================================================================
// Module  : add_tree_pipe
// Purpose : Parametrised pipelined unsigned adder tree with valid/ready on
//           both sides and bubble-collapsing backpressure. One register level
//           per tree level, full precision inside the tree, final reduction
//           to OUT_W bits with an overflow flag.
// Config  : ADD_TREE_SAT_EN - when defined, an overflowing result saturates to
//           all ones instead of wrapping modulo 2^OUT_W.
// Ports   : clk       - clock, rising edge
//           rst_n     - asynchronous reset, active low
//           in_valid  - operand vector valid
//           in_ready  - tree accepts a vector this cycle
//           in_data   - NUM_IN operands, operand i = in_data[i*IN_W +: IN_W]
//           out_valid - result valid
//           out_ready - consumer accepts result this cycle
//           out_sum   - reduced sum (OUT_W bits)
//           out_ovf   - full sum exceeded 2^OUT_W-1, qualified by out_valid
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module add_tree_pipe
  import add_tree_pkg::*;
#(
  parameter int NUM_IN = 8,
  parameter int IN_W   = 8,
  parameter int OUT_W  = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NUM_IN*IN_W-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_W-1:0]       out_sum,
  output logic                   out_ovf
);

  localparam int LEVELS = calc_levels(NUM_IN);
  localparam int FULL_W = calc_full_w(NUM_IN, IN_W);
  localparam int BUS_W  = bus_offset(NUM_IN, IN_W, LEVELS + 1);

  // All tree levels packed back to back; every bit has exactly one driver
  // and one reader.
  logic [BUS_W-1:0]  w_bus;
  logic [LEVELS-1:0] w_v;
  logic [LEVELS-1:0] w_vin;
  logic [LEVELS-1:0] w_adv;
  logic [FULL_W-1:0] w_full;
  logic [OUT_W-1:0]  w_trunc;
  logic              w_ovf;

  assign w_bus[NUM_IN*IN_W-1:0] = in_data;

  for (genvar k = 0; k < LEVELS; k++) begin : g_level
    localparam int NP      = NUM_IN >> (k + 1);
    localparam int SW      = IN_W + k;
    localparam int OFF_IN  = bus_offset(NUM_IN, IN_W, k);
    localparam int OFF_OUT = bus_offset(NUM_IN, IN_W, k + 1);

    if (k == 0) begin : g_vin_first
      assign w_vin[k] = in_valid;
    end else begin : g_vin_chain
      assign w_vin[k] = w_v[k-1];
    end

    // A stage may advance when the consumer takes the result or any stage
    // from here to the output holds a bubble (bubble collapsing). This is
    // the unrolled form of adv[k] = adv[k+1] | ~v[k].
    assign w_adv[k] = out_ready | ~(&w_v[LEVELS-1:k]);

    add_tree_stage #(
      .N_PAIRS (NP),
      .W       (SW)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_adv   (w_adv[k]),
      .i_valid (w_vin[k]),
      .i_data  (w_bus[OFF_IN  +: 2*NP*SW]),
      .o_valid (w_v[k]),
      .o_data  (w_bus[OFF_OUT +: NP*(SW+1)])
    );
  end

  assign in_ready  = w_adv[0];
  assign out_valid = w_v[LEVELS-1];

  assign w_full  = w_bus[BUS_W-1 -: FULL_W];
  assign w_trunc = w_full[OUT_W-1:0];

  if (OUT_W == FULL_W) begin : g_no_ovf
    assign w_ovf = 1'b0;
  end else begin : g_ovf
    assign w_ovf = |w_full[FULL_W-1:OUT_W];
  end

`ifdef ADD_TREE_SAT_EN
  assign out_sum = w_ovf ? {OUT_W{1'b1}} : w_trunc;
`else
  assign out_sum = w_trunc;
`endif

  assign out_ovf = w_ovf;

endmodule

`default_nettype wire
